// File: rtl/atm_pkg.sv
// Shared codes for the ATM transaction sequencer: state/menu encodings,
// button bit positions, display fill patterns and small BCD digit helpers.
package atm_pkg;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_PIN    = 3'd1,
    ST_MENU   = 3'd2,
    ST_AMOUNT = 3'd3,
    ST_SHOW   = 3'd4,
    ST_ERR    = 3'd5,
    ST_LOCK   = 3'd6
  } state_t;

  localparam logic [1:0] SEL_BAL = 2'd0;
  localparam logic [1:0] SEL_WDR = 2'd1;
  localparam logic [1:0] SEL_DEP = 2'd2;

  localparam int BTN_C = 0;
  localparam int BTN_U = 1;
  localparam int BTN_D = 2;
  localparam int BTN_L = 3;
  localparam int BTN_R = 4;

  localparam logic [15:0] ERR_PATTERN  = 16'hEEEE;
  localparam logic [15:0] LOCK_PATTERN = 16'hFFFF;

  typedef enum logic [2:0] {
    ACT_NONE,
    ACT_C,
    ACT_U,
    ACT_D,
    ACT_L,
    ACT_R
  } act_t;

  // Several simultaneous pulses collapse to the single highest-priority one.
  function automatic act_t btn_decode(input logic [4:0] p);
    if (p[BTN_C])      return ACT_C;
    else if (p[BTN_U]) return ACT_U;
    else if (p[BTN_D]) return ACT_D;
    else if (p[BTN_L]) return ACT_L;
    else if (p[BTN_R]) return ACT_R;
    else               return ACT_NONE;
  endfunction

  function automatic logic [3:0] digit_inc(input logic [3:0] d);
    return (d >= 4'd9) ? 4'd0 : d + 4'd1;
  endfunction

  function automatic logic [3:0] digit_dec(input logic [3:0] d);
    return (d == 4'd0) ? 4'd9 : d - 4'd1;
  endfunction

endpackage

// File: rtl/bcd_addsub4.sv
// Combinational 4-digit BCD add (sub=0) or subtract a-b (sub=1).
// cout is the decimal carry out on add, the borrow out (b > a) on subtract.
module bcd_addsub4 (
  input  logic [15:0] a,
  input  logic [15:0] b,
  input  logic        sub,
  output logic [15:0] result,
  output logic        cout
);

  logic       carry;
  logic [4:0] tmp;

  always_comb begin
    carry  = 1'b0;
    tmp    = '0;
    result = '0;
    for (int i = 0; i < 4; i++) begin
      if (!sub) begin
        tmp = {1'b0, a[4*i +: 4]} + {1'b0, b[4*i +: 4]} + {4'b0, carry};
        carry = (tmp > 5'd9);
        if (carry) tmp = tmp + 5'd6;
      end else begin
        tmp = {1'b0, a[4*i +: 4]} - {1'b0, b[4*i +: 4]} - {4'b0, carry};
        carry = tmp[4];
        if (carry) tmp = tmp + 5'd10;
      end
      result[4*i +: 4] = tmp[3:0];
    end
    cout = carry;
  end

endmodule

// File: rtl/atm_txn_ctrl.sv
// ATM front-panel sequencer: PIN entry, menu, withdraw/deposit/balance, BCD balance.
// Optional ATM_LOCKOUT_EN: MAX_TRIES wrong PINs latch LOCK until reset.
module atm_txn_ctrl
  import atm_pkg::*;
#(
  parameter logic [15:0] PIN            = 16'h1234,
  parameter logic [15:0] INIT_BALANCE   = 16'h0500,
  parameter int          MAX_TRIES      = 3,
  parameter int          TIMEOUT_CYCLES = 40
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [4:0]  btn_pulse,
  output logic [31:0] disp_data,
  output logic [2:0]  state_o,
  output logic        err_o,
  output logic        locked_o
);

  localparam int TW  = $clog2(TIMEOUT_CYCLES);
  localparam int TRW = $clog2(MAX_TRIES + 1);

  state_t           state, state_n;
  logic [15:0]      balance, balance_n;
  logic [15:0]      entry, entry_n;
  logic [1:0]       cursor, cursor_n;
  logic [1:0]       sel, sel_n;
  logic [TRW-1:0]   tries, tries_n;
  logic [TW-1:0]    tcnt, tcnt_n;
  logic             err_from_pin, err_from_pin_n;
  logic [15:0]      value_n;
  logic [3:0]       cursor_disp_n;
  logic [15:0]      arith_res;
  logic             arith_cout;
  act_t             act;

  bcd_addsub4 u_arith (
    .a      (balance),
    .b      (entry),
    .sub    (sel == SEL_WDR),
    .result (arith_res),
    .cout   (arith_cout)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state        <= ST_IDLE;
      balance      <= INIT_BALANCE;
      entry        <= '0;
      cursor       <= '0;
      sel          <= SEL_BAL;
      tries        <= '0;
      tcnt         <= '0;
      err_from_pin <= 1'b0;
      disp_data    <= '0;
      state_o      <= '0;
      err_o        <= 1'b0;
      locked_o     <= 1'b0;
    end else begin
      state        <= state_n;
      balance      <= balance_n;
      entry        <= entry_n;
      cursor       <= cursor_n;
      sel          <= sel_n;
      tries        <= tries_n;
      tcnt         <= tcnt_n;
      err_from_pin <= err_from_pin_n;
      disp_data    <= {state_n, 8'h00, cursor_disp_n, value_n};
      state_o      <= state_n;
      err_o        <= (state_n == ST_ERR);
      locked_o     <= (state_n == ST_LOCK);
    end
  end

  always_comb begin
    state_n        = state;
    balance_n      = balance;
    entry_n        = entry;
    cursor_n       = cursor;
    sel_n          = sel;
    tries_n        = tries;
    tcnt_n         = '0;
    err_from_pin_n = err_from_pin;
    act            = btn_decode(btn_pulse);

    if (state inside {ST_PIN, ST_MENU, ST_AMOUNT, ST_SHOW, ST_ERR} && act == ACT_NONE)
      tcnt_n = tcnt + TW'(1);

    case (state)
      ST_IDLE: begin
        if (act != ACT_NONE) begin
          state_n  = ST_PIN;
          entry_n  = '0;
          cursor_n = 2'd3;
        end
      end
      ST_PIN, ST_AMOUNT: begin
        case (act)
          ACT_U: entry_n[{cursor, 2'b00} +: 4] = digit_inc(entry[{cursor, 2'b00} +: 4]);
          ACT_D: entry_n[{cursor, 2'b00} +: 4] = digit_dec(entry[{cursor, 2'b00} +: 4]);
          ACT_L: if (cursor != 2'd3) cursor_n = cursor + 2'd1;
          ACT_R: if (cursor != 2'd0) cursor_n = cursor - 2'd1;
          ACT_C: begin
            if (state == ST_PIN) begin
              if (entry == PIN) begin
                state_n = ST_MENU;
                tries_n = '0;
                sel_n   = SEL_BAL;
              end else begin
                if (tries != TRW'(MAX_TRIES)) tries_n = tries + TRW'(1);
                err_from_pin_n = 1'b1;
`ifdef ATM_LOCKOUT_EN
                state_n = (tries_n == TRW'(MAX_TRIES)) ? ST_LOCK : ST_ERR;
`else
                state_n = ST_ERR;
`endif
              end
            end else begin
              // Carry on deposit / borrow on withdraw both mean "reject".
              err_from_pin_n = 1'b0;
              if (arith_cout) begin
                state_n = ST_ERR;
              end else begin
                balance_n = arith_res;
                state_n   = ST_SHOW;
              end
            end
          end
          default: ;
        endcase
      end
      ST_MENU: begin
        case (act)
          ACT_U: sel_n = (sel == SEL_DEP) ? SEL_BAL : sel + 2'd1;
          ACT_D: sel_n = (sel == SEL_BAL) ? SEL_DEP : sel - 2'd1;
          ACT_L: begin
            state_n  = ST_IDLE;
            entry_n  = '0;
            cursor_n = '0;
          end
          ACT_C: begin
            if (sel == SEL_BAL) begin
              state_n = ST_SHOW;
            end else begin
              state_n  = ST_AMOUNT;
              entry_n  = '0;
              cursor_n = 2'd3;
            end
          end
          default: ;
        endcase
      end
      ST_SHOW: begin
        if (act == ACT_C) state_n = ST_MENU;
      end
      ST_ERR: begin
        if (act == ACT_C) begin
          if (err_from_pin) begin
            state_n  = ST_PIN;
            entry_n  = '0;
            cursor_n = 2'd3;
          end else begin
            state_n = ST_MENU;
          end
        end
      end
      default: ;
    endcase

    if (tcnt_n == TW'(TIMEOUT_CYCLES - 1)) begin
      state_n  = ST_IDLE;
      entry_n  = '0;
      cursor_n = '0;
      tcnt_n   = '0;
    end
  end

  always_comb begin
    value_n       = '0;
    cursor_disp_n = '0;
    case (state_n)
      ST_PIN, ST_AMOUNT: begin
        value_n       = entry_n;
        cursor_disp_n = {2'b00, cursor_n};
      end
      ST_MENU: value_n = {14'd0, sel_n};
      ST_SHOW: value_n = balance_n;
      ST_ERR:  value_n = ERR_PATTERN;
      ST_LOCK: value_n = LOCK_PATTERN;
      default: value_n = '0;
    endcase
  end

endmodule

// File: tb/tb_atm_txn_ctrl.sv
// Directed-vector bench for atm_txn_ctrl; expected display words are hand-computed.
module tb_atm_txn_ctrl;

  logic        clk;
  logic        rst;
  logic [4:0]  btn_pulse;
  logic [31:0] disp_data;
  logic [2:0]  state_o;
  logic        err_o;
  logic        locked_o;

  int n_vec = 0;
  int n_err = 0;

  localparam logic [4:0] B_C = 5'b00001;
  localparam logic [4:0] B_U = 5'b00010;
  localparam logic [4:0] B_D = 5'b00100;
  localparam logic [4:0] B_L = 5'b01000;
  localparam logic [4:0] B_R = 5'b10000;

  atm_txn_ctrl dut (
    .clk       (clk),
    .rst       (rst),
    .btn_pulse (btn_pulse),
    .disp_data (disp_data),
    .state_o   (state_o),
    .err_o     (err_o),
    .locked_o  (locked_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic press(input logic [4:0] b);
    @(negedge clk);
    btn_pulse = b;
    @(negedge clk);
    btn_pulse = '0;
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b0;
    btn_pulse = '0;
    idle(2);
    rst = 1'b1;
  endtask

  // Starts at cursor 3 with entry 0000; leaves cursor at 0.
  task automatic enter_digits(input logic [15:0] v);
    logic [3:0] d;
    for (int p = 3; p >= 0; p--) begin
      d = v[4*p +: 4];
      if (d <= 4'd5) repeat (int'(d)) press(B_U);
      else           repeat (10 - int'(d)) press(B_D);
      if (p > 0) press(B_R);
    end
  endtask

  task automatic login();
    press(B_C);
    enter_digits(16'h1234);
    press(B_C);
  endtask

  initial begin
    rst = 1'b0;
    btn_pulse = '0;
    idle(3);
    chk("reset_disp", disp_data, 32'h0);
    chk("reset_state", 32'(state_o), 32'd0);
    chk("reset_flags", {30'd0, err_o, locked_o}, 32'd0);
    rst = 1'b1;

    // PIN entry, digit wraps, cursor saturation
    press(B_C);
    chk("idle_to_pin", disp_data, 32'h1003_0000);
    press(B_L);
    chk("cursor_sat_hi", disp_data, 32'h1003_0000);
    press(B_D);
    chk("digit_wrap_0_to_9", disp_data, 32'h1003_9000);
    press(B_U);
    chk("digit_wrap_9_to_0", disp_data, 32'h1003_0000);
    enter_digits(16'h1234);
    chk("pin_entered", disp_data, 32'h1000_1234);
    press(B_R);
    chk("cursor_sat_lo", disp_data, 32'h1000_1234);
    press(B_C);
    chk("pin_ok_menu", disp_data, 32'h2000_0000);
    chk("pin_ok_state", 32'(state_o), 32'd2);

    // Withdraw 0200 then an over-balance 0400
    press(B_U);
    chk("menu_sel_wdr", disp_data, 32'h2000_0001);
    press(B_C);
    chk("menu_to_amount", disp_data, 32'h3003_0000);
    enter_digits(16'h0200);
    press(B_C);
    chk("withdraw_200", disp_data, 32'h4000_0300);
    press(B_C);
    chk("show_to_menu", disp_data, 32'h2000_0001);
    press(B_C);
    enter_digits(16'h0400);
    press(B_C);
    chk("withdraw_over", disp_data, 32'h5000_EEEE);
    chk("withdraw_over_err", 32'(err_o), 32'd1);
    press(B_C);
    chk("err_to_menu", disp_data, 32'h2000_0001);
    press(B_D);
    press(B_C);
    chk("balance_kept_300", disp_data, 32'h4000_0300);

    // Deposit carry-out, deposit to 9999, withdraw everything
    do_reset();
    login();
    press(B_D);
    chk("menu_sel_wrap_dep", disp_data, 32'h2000_0002);
    press(B_C);
    enter_digits(16'h9600);
    press(B_C);
    chk("deposit_carry", disp_data, 32'h5000_EEEE);
    press(B_C);
    press(B_C);
    enter_digits(16'h9499);
    press(B_C);
    chk("deposit_9999", disp_data, 32'h4000_9999);
    press(B_C);
    press(B_D);
    press(B_C);
    enter_digits(16'h9999);
    press(B_C);
    chk("withdraw_all", disp_data, 32'h4000_0000);

    // Wrong PIN three times
    do_reset();
    press(B_C);
    press(B_C);
    chk("wrong_pin_1", disp_data, 32'h5000_EEEE);
    press(B_C);
    chk("err_to_pin", disp_data, 32'h1003_0000);
    press(B_C);
    press(B_C);
    press(B_C);
`ifdef ATM_LOCKOUT_EN
    chk("wrong_pin_3_lock", disp_data, 32'h6000_FFFF);
    chk("lock_flags", {30'd0, err_o, locked_o}, 32'd1);
    press(B_C);
    press(B_U);
    idle(50);
    chk("lock_sticky", disp_data, 32'h6000_FFFF);
`else
    chk("wrong_pin_3_err", disp_data, 32'h5000_EEEE);
    chk("err_flags", {30'd0, err_o, locked_o}, 32'd2);
    press(B_C);
    enter_digits(16'h1234);
    press(B_C);
    chk("no_lock_login", disp_data, 32'h2000_0000);
`endif

    // Logout and inactivity timeout
    do_reset();
    login();
    press(B_L);
    chk("menu_logout", disp_data, 32'h0);
    login();
    idle(38);
    chk("timeout_38_menu", disp_data, 32'h2000_0000);
    idle(1);
    chk("timeout_39_idle", disp_data, 32'h0);
    login();
    idle(37);
    press(B_U);
    idle(38);
    chk("timeout_restart", disp_data, 32'h2000_0001);
    idle(1);
    chk("timeout_after_restart", disp_data, 32'h0);

    // Simultaneous pulses, reset mid-AMOUNT
    do_reset();
    press(B_C);
    enter_digits(16'h1234);
    press(B_C | B_U);
    chk("priority_center", disp_data, 32'h2000_0000);
    press(B_U);
    press(B_C);
    press(B_U);
    chk("amount_partial", disp_data, 32'h3003_1000);
    @(negedge clk);
    #2 rst = 1'b0;
    #1;
    chk("async_rst_disp", disp_data, 32'h0);
    chk("async_rst_state", 32'(state_o), 32'd0);
    @(negedge clk);
    rst = 1'b1;
    login();
    press(B_C);
    chk("balance_restored", disp_data, 32'h4000_0500);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
